// File: rtl/gpu_barrier_controller.sv
// CTA barrier tracker: slot table of in-flight barriers, arrival accounting and release arbitration.
// Optional per-slot timeout with forced release is enabled by defining GPU_BARRIER_TIMEOUT_EN.
module gpu_barrier_controller #(
  parameter int unsigned NUM_WARPS      = 32,
  parameter int unsigned NUM_SLOTS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          barrier_id,
  input  logic [9:0]           block_id,
  input  logic [5:0]           warp_id,
  input  logic [NUM_WARPS-1:0] expected_mask,
  input  logic                 request_valid,
  output logic                 ready,
  output logic [15:0]          release_barrier_id,
  output logic [9:0]           release_block_id,
  output logic [NUM_WARPS-1:0] release_warp_mask,
  output logic                 release_valid,
`ifdef GPU_BARRIER_TIMEOUT_EN
  output logic                 release_timeout,
`endif
  input  logic                 release_ready,
  output logic                 stall,
  output logic [NUM_WARPS-1:0] stall_warp_mask,
  output logic                 err_dup,
  output logic                 err_range
);

  localparam int unsigned SlotW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {SlotFree, SlotWait, SlotDone} slot_state_e;

  slot_state_e          state_q [NUM_SLOTS];
  slot_state_e          state_d [NUM_SLOTS];
  logic [15:0]          bid_q   [NUM_SLOTS];
  logic [15:0]          bid_d   [NUM_SLOTS];
  logic [9:0]           blk_q   [NUM_SLOTS];
  logic [9:0]           blk_d   [NUM_SLOTS];
  logic [NUM_WARPS-1:0] exp_q   [NUM_SLOTS];
  logic [NUM_WARPS-1:0] exp_d   [NUM_SLOTS];
  logic [NUM_WARPS-1:0] arr_q   [NUM_SLOTS];
  logic [NUM_WARPS-1:0] arr_d   [NUM_SLOTS];

  logic                 rel_valid_q, rel_valid_d;
  logic [SlotW-1:0]     rel_slot_q, rel_slot_d;
  logic [15:0]          rel_bid_q, rel_bid_d;
  logic [9:0]           rel_blk_q, rel_blk_d;
  logic [NUM_WARPS-1:0] rel_mask_q, rel_mask_d;
  logic                 err_dup_q, err_dup_d;
  logic                 err_range_q, err_range_d;

`ifdef GPU_BARRIER_TIMEOUT_EN
  logic [15:0]          cnt_q [NUM_SLOTS];
  logic [15:0]          cnt_d [NUM_SLOTS];
  logic                 to_q  [NUM_SLOTS];
  logic                 to_d  [NUM_SLOTS];
  logic                 rel_to_q, rel_to_d;
`else
  logic                 unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  logic                 match_found, free_found, range_err, accept, rel_sel;
  logic [SlotW-1:0]     match_idx, free_idx, rel_idx;
  logic [NUM_WARPS-1:0] warp_bit;

  // Descending scans so the lowest index wins.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (state_q[i] == SlotWait && bid_q[i] == barrier_id && blk_q[i] == block_id) begin
        match_found = 1'b1;
        match_idx   = SlotW'(i);
      end
      if (state_q[i] == SlotFree) begin
        free_found = 1'b1;
        free_idx   = SlotW'(i);
      end
    end
  end

  assign range_err = (32'(warp_id) >= NUM_WARPS);
  assign warp_bit  = NUM_WARPS'(1) << warp_id;
  assign ready     = match_found | free_found;
  assign accept    = request_valid & ready;

  always_comb begin
    state_d     = state_q;
    bid_d       = bid_q;
    blk_d       = blk_q;
    exp_d       = exp_q;
    arr_d       = arr_q;
    rel_valid_d = rel_valid_q;
    rel_slot_d  = rel_slot_q;
    rel_bid_d   = rel_bid_q;
    rel_blk_d   = rel_blk_q;
    rel_mask_d  = rel_mask_q;
    err_dup_d   = 1'b0;
    err_range_d = 1'b0;
    rel_sel     = 1'b0;
    rel_idx     = '0;
`ifdef GPU_BARRIER_TIMEOUT_EN
    cnt_d       = cnt_q;
    to_d        = to_q;
    rel_to_d    = rel_to_q;
`endif

    // Completion is judged on the registered arrived mask, one edge after the last arrival.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (state_q[i] == SlotWait) begin
        if (arr_q[i] == exp_q[i]) begin
          state_d[i] = SlotDone;
`ifdef GPU_BARRIER_TIMEOUT_EN
        end else if (cnt_q[i] == 16'(TIMEOUT_CYCLES)) begin
          state_d[i] = SlotDone;
          to_d[i]    = 1'b1;
`endif
        end
`ifdef GPU_BARRIER_TIMEOUT_EN
        cnt_d[i] = cnt_q[i] + 16'd1;
`endif
      end
    end

    if (accept) begin
      if (range_err) begin
        err_range_d = 1'b1;
      end else if (match_found) begin
        if ((arr_q[match_idx] & warp_bit) != '0) begin
          err_dup_d = 1'b1;
        end else begin
          arr_d[match_idx] = arr_q[match_idx] | warp_bit;
        end
`ifdef GPU_BARRIER_TIMEOUT_EN
        cnt_d[match_idx] = '0;
`endif
      end else begin
        state_d[free_idx] = SlotWait;
        bid_d[free_idx]   = barrier_id;
        blk_d[free_idx]   = block_id;
        exp_d[free_idx]   = expected_mask;
        arr_d[free_idx]   = warp_bit;
`ifdef GPU_BARRIER_TIMEOUT_EN
        cnt_d[free_idx]   = '0;
        to_d[free_idx]    = 1'b0;
`endif
      end
    end

    // The holding stage reloads only from empty, which leaves a bubble after each handshake.
    if (rel_valid_q) begin
      if (release_ready) begin
        state_d[rel_slot_q] = SlotFree;
        rel_valid_d         = 1'b0;
      end
    end else begin
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
        if (state_d[i] == SlotDone) begin
          rel_sel = 1'b1;
          rel_idx = SlotW'(i);
        end
      end
      if (rel_sel) begin
        rel_valid_d = 1'b1;
        rel_slot_d  = rel_idx;
        rel_bid_d   = bid_q[rel_idx];
        rel_blk_d   = blk_q[rel_idx];
        rel_mask_d  = arr_d[rel_idx];
`ifdef GPU_BARRIER_TIMEOUT_EN
        rel_to_d    = to_d[rel_idx];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= SlotFree;
        bid_q[i]   <= '0;
        blk_q[i]   <= '0;
        exp_q[i]   <= '0;
        arr_q[i]   <= '0;
`ifdef GPU_BARRIER_TIMEOUT_EN
        cnt_q[i]   <= '0;
        to_q[i]    <= 1'b0;
`endif
      end
      rel_valid_q <= 1'b0;
      rel_slot_q  <= '0;
      rel_bid_q   <= '0;
      rel_blk_q   <= '0;
      rel_mask_q  <= '0;
      err_dup_q   <= 1'b0;
      err_range_q <= 1'b0;
`ifdef GPU_BARRIER_TIMEOUT_EN
      rel_to_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bid_q       <= bid_d;
      blk_q       <= blk_d;
      exp_q       <= exp_d;
      arr_q       <= arr_d;
      rel_valid_q <= rel_valid_d;
      rel_slot_q  <= rel_slot_d;
      rel_bid_q   <= rel_bid_d;
      rel_blk_q   <= rel_blk_d;
      rel_mask_q  <= rel_mask_d;
      err_dup_q   <= err_dup_d;
      err_range_q <= err_range_d;
`ifdef GPU_BARRIER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      rel_to_q    <= rel_to_d;
`endif
    end
  end

  always_comb begin
    stall_warp_mask = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (state_q[i] != SlotFree) begin
        stall_warp_mask = stall_warp_mask | arr_q[i];
      end
    end
  end

  assign stall              = |stall_warp_mask;
  assign release_valid      = rel_valid_q;
  assign release_barrier_id = rel_bid_q;
  assign release_block_id   = rel_blk_q;
  assign release_warp_mask  = rel_mask_q;
  assign err_dup            = err_dup_q;
  assign err_range          = err_range_q;
`ifdef GPU_BARRIER_TIMEOUT_EN
  assign release_timeout    = rel_to_q;
`endif

endmodule

// File: tb/tb_gpu_barrier_controller.sv
// Directed bench for gpu_barrier_controller: vector table for single-barrier flows plus
// hand-written sequences for table-full back-pressure, release ordering and async reset.
module tb_gpu_barrier_controller;

  logic        clk;
  logic        rst_n;
  logic [15:0] barrier_id;
  logic [9:0]  block_id;
  logic [5:0]  warp_id;
  logic [31:0] expected_mask;
  logic        request_valid;
  logic        ready;
  logic [15:0] release_barrier_id;
  logic [9:0]  release_block_id;
  logic [31:0] release_warp_mask;
  logic        release_valid;
  logic        release_ready;
  logic        stall;
  logic [31:0] stall_warp_mask;
  logic        err_dup;
  logic        err_range;

  int total;
  int bad;

  gpu_barrier_controller dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .barrier_id         (barrier_id),
    .block_id           (block_id),
    .warp_id            (warp_id),
    .expected_mask      (expected_mask),
    .request_valid      (request_valid),
    .ready              (ready),
    .release_barrier_id (release_barrier_id),
    .release_block_id   (release_block_id),
    .release_warp_mask  (release_warp_mask),
    .release_valid      (release_valid),
`ifdef GPU_BARRIER_TIMEOUT_EN
    .release_timeout    (),
`endif
    .release_ready      (release_ready),
    .stall              (stall),
    .stall_warp_mask    (stall_warp_mask),
    .err_dup            (err_dup),
    .err_range          (err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        req;
    logic [15:0] bid;
    logic [9:0]  blk;
    logic [5:0]  wid;
    logic [31:0] emask;
    logic        rr;
    logic        e_ready;
    logic        e_rv;
    logic [15:0] e_rbid;
    logic [9:0]  e_rblk;
    logic [31:0] e_rmask;
    logic [31:0] e_stall;
    logic        e_dup;
    logic        e_rng;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic req, input logic [15:0] bid, input logic [9:0] blk,
                              input logic [5:0] wid, input logic [31:0] emask, input logic rr,
                              input logic e_rv, input logic [15:0] e_rbid,
                              input logic [9:0] e_rblk, input logic [31:0] e_rmask,
                              input logic [31:0] e_stall, input logic e_dup, input logic e_rng);
    vec_t v;
    v.req = req; v.bid = bid; v.blk = blk; v.wid = wid; v.emask = emask; v.rr = rr;
    v.e_ready = 1'b1; v.e_rv = e_rv; v.e_rbid = e_rbid; v.e_rblk = e_rblk;
    v.e_rmask = e_rmask; v.e_stall = e_stall; v.e_dup = e_dup; v.e_rng = e_rng;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are sampled 1 time unit later.
  task automatic step(input logic req, input logic [15:0] bid, input logic [9:0] blk,
                      input logic [5:0] wid, input logic [31:0] emask, input logic rr);
    @(negedge clk);
    request_valid = req;
    barrier_id    = bid;
    block_id      = blk;
    warp_id       = wid;
    expected_mask = emask;
    release_ready = rr;
    #1;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 16'd0, 10'd0, 6'd0, 32'd0, rr);
  endtask

  task automatic check_rel(input string name, input logic [15:0] bid, input logic [31:0] mask);
    check({name, "_rv"}, 64'(release_valid), 64'd1);
    check({name, "_rbid"}, 64'(release_barrier_id), 64'(bid));
    check({name, "_rmask"}, 64'(release_warp_mask), 64'(mask));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    request_valid = 1'b0;
    barrier_id = '0;
    block_id = '0;
    warp_id = '0;
    expected_mask = '0;
    release_ready = 1'b0;

    //            req bid blk wid emask        rr | rv rbid rblk rmask  stall  dup rng
    vecs[0]  = mk(0, 0, 0, 0,  32'h0,   0,  0, 0, 0, 32'h0, 32'h0, 0, 0);
    vecs[1]  = mk(1, 1, 3, 0,  32'hF,   0,  0, 0, 0, 32'h0, 32'h0, 0, 0);
    vecs[2]  = mk(1, 1, 3, 1,  32'hF,   0,  0, 0, 0, 32'h0, 32'h1, 0, 0);
    vecs[3]  = mk(1, 1, 3, 2,  32'hF,   0,  0, 0, 0, 32'h0, 32'h3, 0, 0);
    vecs[4]  = mk(1, 1, 3, 3,  32'hF,   0,  0, 0, 0, 32'h0, 32'h7, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0,  32'h0,   0,  0, 0, 0, 32'h0, 32'hF, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0,  32'h0,   1,  1, 1, 3, 32'hF, 32'hF, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0,  32'h0,   0,  0, 0, 0, 32'h0, 32'h0, 0, 0);
    vecs[8]  = mk(1, 2, 5, 2,  32'h5,   0,  0, 0, 0, 32'h0, 32'h0, 0, 0);
    vecs[9]  = mk(1, 2, 5, 2,  32'h5,   0,  0, 0, 0, 32'h0, 32'h4, 0, 0);
    vecs[10] = mk(0, 0, 0, 0,  32'h0,   0,  0, 0, 0, 32'h0, 32'h4, 1, 0);
    vecs[11] = mk(1, 2, 5, 0,  32'h5,   0,  0, 0, 0, 32'h0, 32'h4, 0, 0);
    vecs[12] = mk(0, 0, 0, 0,  32'h0,   1,  0, 0, 0, 32'h0, 32'h5, 0, 0);
    vecs[13] = mk(0, 0, 0, 0,  32'h0,   1,  1, 2, 5, 32'h5, 32'h5, 0, 0);
    vecs[14] = mk(0, 0, 0, 0,  32'h0,   0,  0, 0, 0, 32'h0, 32'h0, 0, 0);
    vecs[15] = mk(1, 3, 1, 40, 32'h1,   0,  0, 0, 0, 32'h0, 32'h0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0,  32'h0,   0,  0, 0, 0, 32'h0, 32'h0, 0, 1);
    vecs[17] = mk(0, 0, 0, 0,  32'h0,   0,  0, 0, 0, 32'h0, 32'h0, 0, 0);

    @(negedge clk);
    #1;
    check("reset_rv", 64'(release_valid), 64'd0);
    check("reset_stall", 64'(stall_warp_mask), 64'd0);
    check("reset_errs", 64'({err_dup, err_range, stall}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].req, vecs[i].bid, vecs[i].blk, vecs[i].wid, vecs[i].emask, vecs[i].rr);
      check($sformatf("v%0d_ready", i), 64'(ready), 64'(vecs[i].e_ready));
      check($sformatf("v%0d_rv", i), 64'(release_valid), 64'(vecs[i].e_rv));
      check($sformatf("v%0d_stall", i), 64'(stall_warp_mask), 64'(vecs[i].e_stall));
      check($sformatf("v%0d_dup", i), 64'(err_dup), 64'(vecs[i].e_dup));
      check($sformatf("v%0d_rng", i), 64'(err_range), 64'(vecs[i].e_rng));
      if (vecs[i].e_rv) begin
        check($sformatf("v%0d_rbid", i), 64'(release_barrier_id), 64'(vecs[i].e_rbid));
        check($sformatf("v%0d_rblk", i), 64'(release_block_id), 64'(vecs[i].e_rblk));
        check($sformatf("v%0d_rmask", i), 64'(release_warp_mask), 64'(vecs[i].e_rmask));
      end
    end

    // Fill all four slots, then a fifth barrier must be back-pressured.
    for (int b = 10; b < 14; b++) step(1'b1, 16'(b), 10'd0, 6'd0, 32'h3, 1'b0);
    step(1'b1, 16'd14, 10'd0, 6'd0, 32'h3, 1'b0);
    check("full_ready", 64'(ready), 64'd0);
    check("full_stall", 64'(stall_warp_mask), 64'h1);
    step(1'b1, 16'd10, 10'd0, 6'd1, 32'h3, 1'b0);
    check("full_match_ready", 64'(ready), 64'd1);
    idle(1'b1);
    check("b10_not_yet", 64'(release_valid), 64'd0);
    step(1'b1, 16'd14, 10'd0, 6'd0, 32'h3, 1'b1);
    check_rel("b10", 16'd10, 32'h3);
    check("ready_before_hs", 64'(ready), 64'd0);
    step(1'b1, 16'd14, 10'd0, 6'd0, 32'h3, 1'b1);
    check("ready_after_hs", 64'(ready), 64'd1);
    check("rv_gap_after_b10", 64'(release_valid), 64'd0);

    // Three slots become DONE while the first stays unacknowledged; order follows slot index.
    step(1'b1, 16'd11, 10'd0, 6'd1, 32'h3, 1'b0);
    step(1'b1, 16'd13, 10'd0, 6'd1, 32'h3, 1'b0);
    step(1'b1, 16'd14, 10'd0, 6'd1, 32'h3, 1'b0);
    check_rel("b11_hold0", 16'd11, 32'h3);
    for (int k = 1; k < 5; k++) begin
      idle(1'b0);
      check_rel($sformatf("b11_hold%0d", k), 16'd11, 32'h3);
    end
    idle(1'b1);
    check_rel("b11_hs", 16'd11, 32'h3);
    idle(1'b1);
    check("gap_after_b11", 64'(release_valid), 64'd0);
    idle(1'b1);
    check_rel("b14_slot0", 16'd14, 32'h3);
    idle(1'b1);
    check("gap_after_b14", 64'(release_valid), 64'd0);
    idle(1'b1);
    check_rel("b13", 16'd13, 32'h3);
    idle(1'b0);
    check("gap_after_b13", 64'(release_valid), 64'd0);
    check("stall_b12_only", 64'(stall_warp_mask), 64'h1);
    step(1'b1, 16'd12, 10'd0, 6'd1, 32'h3, 1'b0);
    idle(1'b0);
    check("stall_b12_full", 64'(stall_warp_mask), 64'h3);
    idle(1'b1);
    check_rel("b12", 16'd12, 32'h3);
    idle(1'b0);
    check("drained_rv", 64'(release_valid), 64'd0);
    check("drained_stall", 64'(stall), 64'd0);

    // Asynchronous reset drops a pending release immediately.
    step(1'b1, 16'd50, 10'd7, 6'd5, 32'h20, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check_rel("b50", 16'd50, 32'h20);
    check("b50_stall", 64'(stall_warp_mask), 64'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_rv", 64'(release_valid), 64'd0);
    check("midreset_stall", 64'(stall_warp_mask), 64'd0);
    check("midreset_ready", 64'(ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
